// File: rtl/fpu_multiplier_pipe.sv
// fpu_multiplier_pipe
//   Three-stage pipelined IEEE-754 binary multiplier with a valid/ready
//   handshake, RNE/RTZ rounding, subnormal inputs and outputs, and
//   per-result exception flags. The result leaves fully packed.
//
//   Stage 1: classify operands, normalise subnormal significands.
//   Stage 2: significand product, biased exponent sum, special-case select.
//   Stage 3: normalise, denormalise, round, pack into the output register.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready operand handshake (in_ready = pipeline may advance)
//   op_a, op_b        packed operands {sign, exp, frac}
//   rnd_mode          0 = round-nearest-even, 1 = round-toward-zero
//   out_valid/out_ready result handshake
//   result            packed product
//   flag_invalid, flag_overflow, flag_underflow, flag_inexact
//                     exception flags, qualified by out_valid
module fpu_multiplier_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     op_a,
    input  logic [EXP_W+MAN_W:0]     op_b,
    input  logic                     rnd_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     result,
    output logic                     flag_invalid,
    output logic                     flag_overflow,
    output logic                     flag_underflow,
    output logic                     flag_inexact
);

    localparam int BIAS   = 2**(EXP_W-1) - 1;
    localparam int W      = 1 + EXP_W + MAN_W;
    localparam int SIG_W  = MAN_W + 1;
    localparam int PROD_W = 2 * SIG_W;
    localparam int EW     = EXP_W + 2;          // signed working exponent
    localparam int LZC_W  = $clog2(SIG_W + 1);
    localparam int STAGES = 3;

    localparam logic [EW-1:0] ONE     = EW'(1);
    localparam logic [EW-1:0] BIAS_E  = EW'(BIAS);
    localparam logic [EW-1:0] EXP_MAX = {2'b00, {EXP_W{1'b1}}};
    localparam logic [EW-1:0] SH_MAX  = EW'(MAN_W + 3);
    localparam logic [W-1:0]  QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef struct packed {
        logic             sign;
        logic             zero;
        logic             inf;
        logic             nan;
        logic             snan;
        logic [EW-1:0]    exp;   // two's complement, unbiased by nothing
        logic [SIG_W-1:0] sig;   // hidden bit at MSB for every finite nonzero
    } opnd_t;

    // Leading-zero count, MSB has priority (last hit in ascending loop wins).
    function automatic logic [LZC_W-1:0] lzc_f(input logic [SIG_W-1:0] v);
        lzc_f = LZC_W'(SIG_W);
        for (int i = 0; i < SIG_W; i++)
            if (v[i]) lzc_f = LZC_W'(SIG_W - 1 - i);
    endfunction

    function automatic opnd_t unpack_op(input logic [W-1:0] x);
        opnd_t            o;
        logic [EXP_W-1:0] ef;
        logic [MAN_W-1:0] ff;
        logic [SIG_W-1:0] s;
        logic [LZC_W-1:0] lz;
        logic             e_max;
        logic             e_zero;
        ef     = x[W-2 -: EXP_W];
        ff     = x[MAN_W-1:0];
        e_max  = &ef;
        e_zero = ~|ef;
        o      = '0;
        o.sign = x[W-1];
        o.zero = e_zero & ~|ff;
        o.inf  = e_max & ~|ff;
        o.nan  = e_max & |ff;
        o.snan = e_max & ~ff[MAN_W-1] & |ff;
        s      = {1'b0, ff};
        lz     = lzc_f(s);
        if (e_zero) begin
            // Subnormal: shift the leading one into the hidden position.
            o.sig = s << lz;
            o.exp = ONE - EW'(lz);
        end else begin
            o.sig = {1'b1, ff};
            o.exp = {2'b00, ef};
        end
        return o;
    endfunction

    // ------------------------------------------------------------------
    // Handshake / valid pipeline
    // ------------------------------------------------------------------
    logic [STAGES:1] vld_pipe;
    logic            advance;

    assign out_valid = vld_pipe[STAGES];
    assign advance   = ~out_valid | out_ready;
    assign in_ready  = advance;

    // ------------------------------------------------------------------
    // Stage 1: classify / normalise
    // ------------------------------------------------------------------
    opnd_t s1_a, s1_b;
    logic  s1_rnd;

    always_ff @(posedge clk) begin
        if (advance) begin
            s1_a   <= unpack_op(op_a);
            s1_b   <= unpack_op(op_b);
            s1_rnd <= rnd_mode;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: multiply, exponent sum, special-case decode
    // ------------------------------------------------------------------
    logic          sp_hit, sp_inv, sp_sign, inf_zero;
    logic [W-1:0]  sp_res;

    always_comb begin
        sp_hit   = 1'b0;
        sp_inv   = 1'b0;
        sp_res   = '0;
        sp_sign  = s1_a.sign ^ s1_b.sign;
        inf_zero = (s1_a.inf & s1_b.zero) | (s1_a.zero & s1_b.inf);
        if (s1_a.nan | s1_b.nan | inf_zero) begin
            sp_hit = 1'b1;
            sp_res = QNAN;
            sp_inv = s1_a.snan | s1_b.snan | inf_zero;
        end else if (s1_a.inf | s1_b.inf) begin
            sp_hit = 1'b1;
            sp_res = {sp_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (s1_a.zero | s1_b.zero) begin
            sp_hit = 1'b1;
            sp_res = {sp_sign, {(W-1){1'b0}}};
        end
    end

    logic [PROD_W-1:0] s2_prod;
    logic [EW-1:0]     s2_exp;
    logic              s2_sign, s2_rnd, s2_spec, s2_spec_inv;
    logic [W-1:0]      s2_spec_res;

    always_ff @(posedge clk) begin
        if (advance) begin
            s2_prod     <= PROD_W'(s1_a.sig) * PROD_W'(s1_b.sig);
            s2_exp      <= s1_a.exp + s1_b.exp - BIAS_E;
            s2_sign     <= sp_sign;
            s2_rnd      <= s1_rnd;
            s2_spec     <= sp_hit;
            s2_spec_res <= sp_res;
            s2_spec_inv <= sp_inv;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: normalise / round / pack
    // ------------------------------------------------------------------
    logic [PROD_W-1:0] p, mask;
    logic [EW-1:0]     e, dsh;
    logic [SIG_W-1:0]  mant;
    logic [SIG_W:0]    mr;
    logic              st_lo, tiny, g_bit, r_bit, s_bit, inc, ovf, inx;
    logic [W-1:0]      r3;
    logic [3:0]        f3;   // {invalid, overflow, underflow, inexact}

    always_comb begin
        p     = s2_prod;
        e     = s2_exp;
        st_lo = 1'b0;
        tiny  = 1'b0;
        dsh   = '0;
        mask  = '0;
        r3    = '0;
        f3    = '0;
        // Product of two [1,2) significands lies in [1,4).
        if (p[PROD_W-1]) begin
            st_lo = p[0];
            p     = p >> 1;
            e     = e + ONE;
        end
        // Below the normal range: denormalise, collecting lost bits.
        // Past MAN_W+3 every bit is already below the round position.
        if ($signed(e) < $signed(ONE)) begin
            tiny  = 1'b1;
            dsh   = ONE - e;
            if (dsh > SH_MAX) dsh = SH_MAX;
            mask  = (PROD_W'(1) << dsh) - PROD_W'(1);
            st_lo = st_lo | (|(p & mask));
            p     = p >> dsh;
            e     = ONE;
        end
        mant  = p[2*MAN_W -: SIG_W];
        g_bit = p[MAN_W-1];
        r_bit = p[MAN_W-2];
        s_bit = st_lo | (|p[MAN_W-3:0]);
        inc   = ~s2_rnd & g_bit & (r_bit | s_bit | mant[0]);
        mr    = {1'b0, mant} + {{SIG_W{1'b0}}, inc};
        // Carry out of the significand: renormalise. A subnormal rounding
        // into the hidden bit needs nothing here; e is already 1.
        if (mr[SIG_W]) begin
            mr = mr >> 1;
            e  = e + ONE;
        end
        ovf = mr[SIG_W-1] & ($signed(e) >= $signed(EXP_MAX));
        inx = g_bit | r_bit | s_bit | ovf;

        if (s2_spec) begin
            r3 = s2_spec_res;
            f3 = {s2_spec_inv, 3'b000};
        end else if (ovf) begin
            f3 = 4'b0101;
            if (s2_rnd)
                r3 = {s2_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
            else
                r3 = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else begin
            r3 = {s2_sign,
                  mr[SIG_W-1] ? e[EXP_W-1:0] : {EXP_W{1'b0}},
                  mr[MAN_W-1:0]};
            f3 = {2'b00, tiny & inx, inx};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe       <= '0;
            result         <= '0;
            flag_invalid   <= 1'b0;
            flag_overflow  <= 1'b0;
            flag_underflow <= 1'b0;
            flag_inexact   <= 1'b0;
        end else if (advance) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
            if (vld_pipe[STAGES-1]) begin
                result <= r3;
                {flag_invalid, flag_overflow, flag_underflow, flag_inexact} <= f3;
            end
        end
    end

endmodule

// File: tb/tb_fpu_multiplier_pipe.sv
// Scoreboard bench for fpu_multiplier_pipe: directed vectors push their
// hand-computed results into a queue; a monitor pops on every output
// transfer and also checks hold-under-stall and in_ready back-pressure.
module tb_fpu_multiplier_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, rnd_mode, out_valid, out_ready;
    logic [31:0] op_a, op_b, result;
    logic        flag_invalid, flag_overflow, flag_underflow, flag_inexact;
    logic [3:0]  flags;

    assign flags = {flag_invalid, flag_overflow, flag_underflow, flag_inexact};

    fpu_multiplier_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .rnd_mode(rnd_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result),
        .flag_invalid(flag_invalid), .flag_overflow(flag_overflow),
        .flag_underflow(flag_underflow), .flag_inexact(flag_inexact)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   rdy_mode = 0;   // 0: always ready, 1: pattern 1,0,0, 2: held low

    // flag encodings {invalid, overflow, underflow, inexact}
    localparam logic [3:0] F_NONE = 4'b0000;
    localparam logic [3:0] F_INV  = 4'b1000;
    localparam logic [3:0] F_X    = 4'b0001;
    localparam logic [3:0] F_UX   = 4'b0011;
    localparam logic [3:0] F_OX   = 4'b0101;

    // out_ready driver
    initial begin
        int cnt;
        cnt = 0;
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (rdy_mode == 0)      out_ready = 1'b1;
            else if (rdy_mode == 2) out_ready = 1'b0;
            else begin
                out_ready = (cnt % 3 == 0);
                cnt++;
            end
        end
    end

    // Monitor
    initial begin
        exp_t        e;
        logic        stalled;
        logic [31:0] prev_res;
        logic [3:0]  prev_flg;
        stalled  = 1'b0;
        prev_res = '0;
        prev_flg = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    checks++;
                    if (!out_valid || result !== prev_res || flags !== prev_flg) begin
                        failures++;
                        $display("FAIL hold: valid=%b result=%h flags=%b, required valid=1 result=%h flags=%b",
                                 out_valid, result, flags, prev_res, prev_flg);
                    end
                end
                if (out_valid && !out_ready) begin
                    checks++;
                    if (in_ready !== 1'b0) begin
                        failures++;
                        $display("FAIL in_ready_stall: in_ready=%b required 0", in_ready);
                    end
                end
                if (out_valid && out_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_output: result=%h flags=%b, none expected", result, flags);
                    end else begin
                        e = exp_q.pop_front();
                        if (result !== e.res || flags !== e.flg) begin
                            failures++;
                            $display("FAIL %s: result=%h flags=%b, required result=%h flags=%b",
                                     e.name, result, flags, e.res, e.flg);
                        end
                    end
                end
                stalled  = out_valid && !out_ready;
                prev_res = result;
                prev_flg = flags;
            end
        end
    end

    // Drive one operand pair; returns after the accepting clock edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic rm,
                        input logic [31:0] er, input logic [3:0] ef,
                        input string nm, input bit push);
        int n;
        if (push) exp_q.push_back('{er, ef, nm});
        @(negedge clk);
        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        rnd_mode = rm;
        n = 0;
        forever begin
            #1;
            if (in_ready) break;
            n++;
            if (n > 200) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout: %s never accepted", nm);
                return;
            end
            @(negedge clk);
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_%s: %0d results outstanding, required 0", nm, exp_q.size());
        end
    endtask

    initial begin
        int lat;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        op_a     = '0;
        op_b     = '0;
        rnd_mode = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        checks++;
        if (out_valid !== 1'b0 || result !== 32'h0 || flags !== 4'h0) begin
            failures++;
            $display("FAIL reset_state: valid=%b result=%h flags=%b, required 0/0/0",
                     out_valid, result, flags);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Latency: accept edge counts as 1, out_valid expected after edge 3.
        send(32'h40000000, 32'h40400000, 1'b0, 32'h40C00000, F_NONE, "basic_2x3", 1);
        idle();
        lat = 1;
        forever begin
            #1;
            if (out_valid || lat > 20) break;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        checks++;
        if (lat != 3) begin
            failures++;
            $display("FAIL latency: %0d cycles, required 3", lat);
        end
        drain("basic");

        // Directed vectors, back to back with out_ready high.
        send(32'h7F800000, 32'h00000000, 1'b0, 32'h7FC00000, F_INV,  "inf_x_zero", 1);
        send(32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, F_INV,  "snan", 1);
        send(32'h7FC00000, 32'h7F800000, 1'b0, 32'h7FC00000, F_NONE, "qnan_x_inf", 1);
        send(32'hFF800000, 32'h40000000, 1'b0, 32'hFF800000, F_NONE, "neginf_x_2", 1);
        send(32'h7F800000, 32'h80000001, 1'b0, 32'hFF800000, F_NONE, "inf_x_negsub", 1);
        send(32'h80000000, 32'h3F800000, 1'b0, 32'h80000000, F_NONE, "negzero_x_1", 1);
        send(32'h3F800001, 32'h3F800001, 1'b0, 32'h3F800002, F_X,    "rne_1ulp_sq", 1);
        send(32'h3F800001, 32'h3F800001, 1'b1, 32'h3F800002, F_X,    "rtz_1ulp_sq", 1);
        send(32'h3FFFFFFF, 32'h3FFFFFFF, 1'b1, 32'h407FFFFE, F_X,    "rtz_max_sig_sq", 1);
        send(32'h3FFFFFFF, 32'h3FFFFFFF, 1'b0, 32'h407FFFFE, F_X,    "rne_max_sig_sq", 1);
        send(32'hC0000000, 32'h40400000, 1'b0, 32'hC0C00000, F_NONE, "neg2_x_3", 1);
        send(32'h00000001, 32'h3F800000, 1'b0, 32'h00000001, F_NONE, "minsub_x_1", 1);
        send(32'h00000001, 32'h3F000000, 1'b0, 32'h00000000, F_UX,   "minsub_half_tie", 1);
        send(32'h00000001, 32'h00000001, 1'b0, 32'h00000000, F_UX,   "sub_x_sub", 1);
        send(32'h00800000, 32'h3F000000, 1'b0, 32'h00400000, F_NONE, "minnorm_half_exact", 1);
        send(32'h007FFFFF, 32'h3F800001, 1'b0, 32'h00800000, F_UX,   "sub_round_to_norm", 1);
        send(32'h007FFFFF, 32'h3F800001, 1'b1, 32'h007FFFFF, F_UX,   "sub_rtz_stays_sub", 1);
        send(32'h7F7FFFFF, 32'h40000000, 1'b0, 32'h7F800000, F_OX,   "ovf_rne", 1);
        send(32'h7F7FFFFF, 32'h40000000, 1'b1, 32'h7F7FFFFF, F_OX,   "ovf_rtz", 1);
        send(32'hFF7FFFFF, 32'h40000000, 1'b1, 32'hFF7FFFFF, F_OX,   "neg_ovf_rtz", 1);
        idle();
        drain("directed");

        // Back-pressure stream.
        rdy_mode = 1;
        send(32'h40000000, 32'h40400000, 1'b0, 32'h40C00000, F_NONE, "bp0", 1);
        send(32'hFF800000, 32'h40000000, 1'b0, 32'hFF800000, F_NONE, "bp1", 1);
        send(32'h3F800001, 32'h3F800001, 1'b0, 32'h3F800002, F_X,    "bp2", 1);
        send(32'h00000001, 32'h3F800000, 1'b0, 32'h00000001, F_NONE, "bp3", 1);
        send(32'hC0000000, 32'h40400000, 1'b0, 32'hC0C00000, F_NONE, "bp4", 1);
        send(32'h00800000, 32'h3F000000, 1'b0, 32'h00400000, F_NONE, "bp5", 1);
        idle();
        drain("stream");

        // Reset with three operations in flight.
        rdy_mode = 2;
        repeat (2) @(negedge clk);
        send(32'h40400000, 32'h40400000, 1'b0, 32'h41100000, F_NONE, "flush0", 0);
        send(32'h40800000, 32'h40400000, 1'b0, 32'h41400000, F_NONE, "flush1", 0);
        send(32'h40A00000, 32'h40400000, 1'b0, 32'h41700000, F_NONE, "flush2", 0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || result !== 32'h0 || flags !== 4'h0) begin
            failures++;
            $display("FAIL async_reset: valid=%b result=%h flags=%b, required 0/0/0",
                     out_valid, result, flags);
        end
        rdy_mode = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send(32'h40000000, 32'h40400000, 1'b0, 32'h40C00000, F_NONE, "post_reset", 1);
        idle();
        drain("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
